i2c_line_conditioner: RTL

- Sits between the MPR121 SCL/SDA pad-cell Y outputs and the I2C master inside khu_sensor_top.
- Synchronizes and deglitches both raw pad inputs, then derives the following from the filtered lines:
  - SCL edge pulses;
  - START and STOP detection;
  - a bus-state FSM (wait / free / busy);
  - arbitration-lost and clock-stretch indications.
- The master consumes filtered lines and events instead of raw asynchronous pad outputs.

---
 rtl/i2c_line_conditioner.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_line_conditioner.sv
// i2c_line_conditioner: synchronizes and deglitches the raw SCL/SDA pad
// outputs, then derives SCL edges, START/STOP, a wait/free/busy bus state,
// arbitration-lost and clock-stretch indications for the I2C master.
module i2c_line_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_CYCLES    = 4,
  parameter int BUSFREE_CYCLES = 64
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_SCL_PAD,
  input  logic i_SDA_PAD,
  input  logic i_SCL_EN,
  input  logic i_SDA_EN,
  input  logic i_MASTER_ACT,
  output logic o_SCL,
  output logic o_SDA,
  output logic o_SCL_RISE,
  output logic o_SCL_FALL,
  output logic o_START,
  output logic o_STOP,
  output logic o_BUS_BUSY,
  output logic o_BUS_FREE,
  output logic o_ARB_LOST,
  output logic o_SCL_STRETCH
);

  localparam int FCW = $clog2(FILT_CYCLES + 1);
  localparam int BCW = $clog2(BUSFREE_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_LAST   = FCW'(FILT_CYCLES - 1);
  localparam logic [BCW-1:0] BUSFREE_MAX = BCW'(BUSFREE_CYCLES);

  typedef enum logic [1:0] {ST_WAIT, ST_FREE, ST_BUSY} bus_state_t;

  // Bus-free counter increment that holds at the terminal count instead of wrapping.
  function automatic logic [BCW-1:0] sat_inc(input logic [BCW-1:0] v);
    return (v == BUSFREE_MAX) ? v : v + BCW'(1);
  endfunction

  // ---- stage p0: metastability synchronizers ----
  logic [SYNC_STAGES-1:0] scl_sync_p0;
  logic [SYNC_STAGES-1:0] sda_sync_p0;
  logic                   scl_smp;
  logic                   sda_smp;

  // Shift the pad levels through the synchronizer chains; idle-high on reset.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
    end else begin
      scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], i_SCL_PAD};
      sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], i_SDA_PAD};
    end
  end

  assign scl_smp = scl_sync_p0[SYNC_STAGES-1];
  assign sda_smp = sda_sync_p0[SYNC_STAGES-1];

  // ---- stage p1: glitch filters ----
  logic           scl_filt_p1;
  logic           sda_filt_p1;
  logic [FCW-1:0] scl_cnt_p1;
  logic [FCW-1:0] sda_cnt_p1;

  // Accept a new level only after FILT_CYCLES consecutive differing samples.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      scl_filt_p1 <= 1'b1;
      sda_filt_p1 <= 1'b1;
      scl_cnt_p1  <= '0;
      sda_cnt_p1  <= '0;
    end else begin
      if (scl_smp == scl_filt_p1) begin
        scl_cnt_p1 <= '0;
      end else if (scl_cnt_p1 == FILT_LAST) begin
        scl_filt_p1 <= scl_smp;
        scl_cnt_p1  <= '0;
      end else begin
        scl_cnt_p1 <= scl_cnt_p1 + FCW'(1);
      end

      if (sda_smp == sda_filt_p1) begin
        sda_cnt_p1 <= '0;
      end else if (sda_cnt_p1 == FILT_LAST) begin
        sda_filt_p1 <= sda_smp;
        sda_cnt_p1  <= '0;
      end else begin
        sda_cnt_p1 <= sda_cnt_p1 + FCW'(1);
      end
    end
  end

  // ---- stage p2: event detection, bus state, registered indications ----
  logic scl_prev_p2;
  logic sda_prev_p2;
  logic scl_rise_det;
  logic scl_fall_det;
  logic start_det;
  logic stop_det;
  logic lines_idle;

  // SDA transitions only count as START/STOP when SCL stayed high across them,
  // which also rules out simultaneous SCL/SDA changes.
  assign scl_rise_det = scl_filt_p1 & ~scl_prev_p2;
  assign scl_fall_det = ~scl_filt_p1 & scl_prev_p2;
  assign start_det    = scl_filt_p1 & scl_prev_p2 & sda_prev_p2 & ~sda_filt_p1;
  assign stop_det     = scl_filt_p1 & scl_prev_p2 & ~sda_prev_p2 & sda_filt_p1;
  assign lines_idle   = scl_filt_p1 & sda_filt_p1;

  bus_state_t     state_p2;
  logic [BCW-1:0] free_cnt_p2;
  logic           bus_busy_p2;
  logic           bus_free_p2;

  // Bus-state FSM with registered busy/free flags updated alongside the state.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_p2    <= ST_WAIT;
      free_cnt_p2 <= '0;
      bus_busy_p2 <= 1'b0;
      bus_free_p2 <= 1'b0;
    end else begin
      case (state_p2)
        ST_WAIT: begin
          if (start_det) begin
            state_p2    <= ST_BUSY;
            free_cnt_p2 <= '0;
            bus_busy_p2 <= 1'b1;
            bus_free_p2 <= 1'b0;
          end else if (!lines_idle) begin
            free_cnt_p2 <= '0;
          end else if (sat_inc(free_cnt_p2) == BUSFREE_MAX) begin
            state_p2    <= ST_FREE;
            free_cnt_p2 <= BUSFREE_MAX;
            bus_free_p2 <= 1'b1;
          end else begin
            free_cnt_p2 <= sat_inc(free_cnt_p2);
          end
        end
        ST_FREE: begin
          if (start_det) begin
            state_p2    <= ST_BUSY;
            free_cnt_p2 <= '0;
            bus_busy_p2 <= 1'b1;
            bus_free_p2 <= 1'b0;
          end else if (!lines_idle) begin
            state_p2    <= ST_WAIT;
            free_cnt_p2 <= '0;
            bus_free_p2 <= 1'b0;
          end
        end
        ST_BUSY: begin
          // A repeated START keeps the bus busy; only STOP releases it.
          if (stop_det) begin
            state_p2    <= ST_WAIT;
            free_cnt_p2 <= '0;
            bus_busy_p2 <= 1'b0;
          end
        end
        default: begin
          state_p2    <= ST_WAIT;
          free_cnt_p2 <= '0;
          bus_busy_p2 <= 1'b0;
          bus_free_p2 <= 1'b0;
        end
      endcase
    end
  end

  logic scl_rise_p2;
  logic scl_fall_p2;
  logic start_p2;
  logic stop_p2;
  logic arb_lost_p2;
  logic stretch_p2;

  // Register one-cycle event pulses plus the arbitration and stretch flags.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      scl_prev_p2 <= 1'b1;
      sda_prev_p2 <= 1'b1;
      scl_rise_p2 <= 1'b0;
      scl_fall_p2 <= 1'b0;
      start_p2    <= 1'b0;
      stop_p2     <= 1'b0;
      arb_lost_p2 <= 1'b0;
      stretch_p2  <= 1'b0;
    end else begin
      scl_prev_p2 <= scl_filt_p1;
      sda_prev_p2 <= sda_filt_p1;
      scl_rise_p2 <= scl_rise_det;
      scl_fall_p2 <= scl_fall_det;
      start_p2    <= start_det;
      stop_p2     <= stop_det;
      // Master released SDA expecting a 1 but the line reads 0 at the SCL rise.
      arb_lost_p2 <= scl_rise_det & i_MASTER_ACT & i_SDA_EN & ~sda_filt_p1 &
                     (state_p2 == ST_BUSY);
      // Master released SCL yet it stays low: a slave is stretching the clock.
      stretch_p2  <= (state_p2 == ST_BUSY) & i_SCL_EN & ~scl_filt_p1;
    end
  end

  assign o_SCL         = scl_filt_p1;
  assign o_SDA         = sda_filt_p1;
  assign o_SCL_RISE    = scl_rise_p2;
  assign o_SCL_FALL    = scl_fall_p2;
  assign o_START       = start_p2;
  assign o_STOP        = stop_p2;
  assign o_BUS_BUSY    = bus_busy_p2;
  assign o_BUS_FREE    = bus_free_p2;
  assign o_ARB_LOST    = arb_lost_p2;
  assign o_SCL_STRETCH = stretch_p2;

endmodule
